// File: rtl/bit_scan_16bit.sv
// Sequential bit scanner: emits the index of each set bit of a loaded word, one per handshake.
// Define BIT_SCAN_MSB_FIRST_EN to emit highest-first instead of lowest-first.
module bit_scan_16bit #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] A,
  input  logic             READY,
  output logic             BUSY,
  output logic             VALID,
  output logic [IDXW-1:0]  BS_OUT,
  output logic             LAST,
  output logic             DONE,
  output logic [IDXW:0]    COUNT
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] w;
  logic [IDXW:0]    count;
  logic [IDXW-1:0]  sel;
  logic             one_hot;

  // Priority pick: the last match in loop order wins.
  always_comb begin
    sel = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (w[i]) sel = IDXW'(i);
`else
    for (int i = WIDTH-1; i >= 0; i--)
      if (w[i]) sel = IDXW'(i);
`endif
  end

  // Only meaningful in SCAN, where w is never zero.
  assign one_hot = ((w & (w - WIDTH'(1))) == '0);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= S_IDLE;
      w     <= '0;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: if (LOAD) begin
          w     <= A;
          count <= '0;
          state <= (A != '0) ? S_SCAN : S_DONE;
        end
        S_SCAN: if (READY) begin
          w     <= w & ~(WIDTH'(1) << sel);
          count <= count + 1'b1;
          if (one_hot) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY   = (state != S_IDLE);
  assign VALID  = (state == S_SCAN);
  assign BS_OUT = VALID ? sel : '0;
  assign LAST   = VALID && one_hot;
  assign DONE   = (state == S_DONE);
  assign COUNT  = count;

endmodule

// File: tb/tb_bit_scan_16bit.sv
// Self-checking bench for bit_scan_16bit: queue-based reference model plus directed literal checks.
module tb_bit_scan_16bit;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] A = '0;
  logic        READY = 1'b0;
  logic        BUSY, VALID, LAST, DONE;
  logic [3:0]  BS_OUT;
  logic [4:0]  COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  bit_scan_16bit dut (
    .CLK(CLK), .RESETN(RESETN), .LOAD(LOAD), .A(A), .READY(READY),
    .BUSY(BUSY), .VALID(VALID), .BS_OUT(BS_OUT), .LAST(LAST),
    .DONE(DONE), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 scanning, 2 done-pulse; q holds indices still to emit.
  int phase = 0;
  int cnt   = 0;
  int q[$];

  always @(negedge RESETN) begin
    phase = 0;
    cnt   = 0;
    q.delete();
  end

  always @(posedge CLK) begin
    if (RESETN) begin
      case (phase)
        0: if (LOAD) begin
          cnt = 0;
          q.delete();
          for (int i = 0; i < 16; i++)
            if (A[i]) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
              q.push_front(i);
`else
              q.push_back(i);
`endif
            end
          phase = (q.size() > 0) ? 1 : 2;
        end
        1: if (READY) begin
          void'(q.pop_front());
          cnt++;
          if (q.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    chk("busy",   int'(BUSY),   int'(phase != 0));
    chk("valid",  int'(VALID),  int'(phase == 1));
    chk("bs_out", int'(BS_OUT), (phase == 1) ? q[0] : 0);
    chk("last",   int'(LAST),   int'(phase == 1 && q.size() == 1));
    chk("done",   int'(DONE),   int'(phase == 2));
    chk("count",  int'(COUNT),  cnt);
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic load_word(input logic [15:0] val);
    LOAD = 1'b1;
    A    = val;
    cyc();
    LOAD = 1'b0;
  endtask

  initial begin
    int exp_seq[4];
    int k;
    logic [15:0] r;

    READY = 1'b1;
    cyc(); cyc();
    chk("rst_busy",  int'(BUSY), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_count", int'(COUNT), 0);
    RESETN = 1'b1;
    cyc();

    // 0x8421 streamed with READY high.
`ifdef BIT_SCAN_MSB_FIRST_EN
    exp_seq = '{15, 10, 5, 0};
`else
    exp_seq = '{0, 5, 10, 15};
`endif
    load_word(16'h8421);
    for (int i = 0; i < 4; i++) begin
      chk("p8421_valid", int'(VALID), 1);
      chk("p8421_idx",   int'(BS_OUT), exp_seq[i]);
      chk("p8421_last",  int'(LAST), int'(i == 3));
      cyc();
    end
    chk("p8421_done",  int'(DONE), 1);
    chk("p8421_count", int'(COUNT), 4);
    cyc();
    chk("p8421_idle", int'(BUSY), 0);

    // Zero word goes straight to DONE.
    load_word(16'h0000);
    chk("zero_done",  int'(DONE), 1);
    chk("zero_busy",  int'(BUSY), 1);
    chk("zero_valid", int'(VALID), 0);
    chk("zero_count", int'(COUNT), 0);
    cyc();
    chk("zero_idle", int'(BUSY), 0);

    // 0x0030 with a 3-cycle stall.
    READY = 1'b0;
    load_word(16'h0030);
    for (int i = 0; i < 3; i++) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
      chk("stall_idx", int'(BS_OUT), 5);
`else
      chk("stall_idx", int'(BS_OUT), 4);
`endif
      chk("stall_last", int'(LAST), 0);
      if (i < 2) cyc();
    end
    READY = 1'b1;
    cyc();
`ifdef BIT_SCAN_MSB_FIRST_EN
    chk("stall_idx2", int'(BS_OUT), 4);
`else
    chk("stall_idx2", int'(BS_OUT), 5);
`endif
    chk("stall_last2", int'(LAST), 1);
    cyc();
    chk("stall_count", int'(COUNT), 2);
    cyc();

    // 0xFFFF with a stray LOAD mid-scan.
    load_word(16'hFFFF);
    k = 1;
    while (!DONE && k < 40) begin
      if (k == 5) begin LOAD = 1'b1; A = 16'h0001; end
      else LOAD = 1'b0;
      cyc();
      k++;
    end
    LOAD = 1'b0;
    chk("full_done_cycle", k, 17);
    chk("full_count", int'(COUNT), 16);
    cyc();

    // Async reset mid-scan of 0x00FF after three accepts.
    load_word(16'h00FF);
    cyc(); cyc(); cyc();
    chk("pre_rst_idx", int'(BS_OUT), 3'd0 + (`ifdef BIT_SCAN_MSB_FIRST_EN 4 `else 3 `endif));
    #3 RESETN = 1'b0;
    #1;
    chk("arst_busy",  int'(BUSY), 0);
    chk("arst_valid", int'(VALID), 0);
    chk("arst_idx",   int'(BS_OUT), 0);
    chk("arst_last",  int'(LAST), 0);
    chk("arst_done",  int'(DONE), 0);
    chk("arst_count", int'(COUNT), 0);
    cyc(); cyc();
    RESETN = 1'b1;
    cyc();
    load_word(16'h0002);
    chk("post_rst_idx",  int'(BS_OUT), 1);
    chk("post_rst_last", int'(LAST), 1);
    cyc(); cyc();

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: r = 16'h0000;
        1: r = 16'h0001 << $urandom_range(0, 15);
        2: r = 16'hFFFF;
        default: r = 16'($urandom);
      endcase
      A     = r;
      LOAD  = ($urandom_range(0, 2) == 0);
      READY = ($urandom_range(0, 3) != 0);
      cyc();
    end
    LOAD = 1'b0;
    READY = 1'b1;
    for (int i = 0; i < 20; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
